btn_debounce_pulse: RTL
=======================

// Module: btn_debounce_pulse
// PURPOSE
//  Upstream conditioning stage for the EGO1 S1 push-button (btn_1).
//  - Synchronises the raw pin, rejects contact bounce and emits a registered clean level.
//  - Emits one-clock press/release strobes.
//  - Output press_pulse (or btn_level) drives the x input of the mod-4 counter stage.
// PARAMETERS
//  DEBOUNCE_CYCLES  2_000_000  stable-input clocks needed to accept a change (20 ms @ 100 MHz)
//  REPEAT_DELAY     50_000_000 clocks held before the first auto-repeat (AUTOREPEAT_EN only)
//  REPEAT_PERIOD    10_000_000 clocks between auto-repeat pulses (AUTOREPEAT_EN only)
// PORTS
//  clk            in   1  system clock, 100 MHz board oscillator
//  rst_n          in   1  synchronous reset, active-low
//  btn_1          in   1  raw S1 pin, active-high, asynchronous to clk, bouncing
//  btn_level      out  1  debounced level, 1 = pressed
//  press_pulse    out  1  one-clock strobe on accepted press (and on auto-repeat)
//  release_pulse  out  1  one-clock strobe on accepted release
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low: sampled on the rising edge of clk while rst_n=0.
//  - Reset values: btn_level=0, press_pulse=0, release_pulse=0, sync FFs=0, counter=0, state=IDLE.
//  - Input path: 2-FF synchroniser on btn_1 gives s. FSM sees s only, never btn_1 directly.
//  - Counter cnt has width $clog2(DEBOUNCE_CYCLES+1).
//    - Cleared on every state change.
//    - Cleared whenever s disagrees with the candidate level.
//    - Saturates; never wraps.
//  - FSM states and transitions:
//    - IDLE (level 0): s=1 -> PRESS_WAIT, cnt=0.
//    - PRESS_WAIT:
//      - s=0 -> IDLE, no pulse (bounce rejected).
//      - s=1 and cnt reaches DEBOUNCE_CYCLES-1 -> PRESSED; press_pulse=1 for exactly the next cycle.
//    - PRESSED (level 1): s=0 -> RELEASE_WAIT, cnt=0.
//    - RELEASE_WAIT:
//      - s=1 -> PRESSED, no pulse.
//      - s=0 for DEBOUNCE_CYCLES -> IDLE; release_pulse=1 for one cycle.
//  - Latency: a clean edge on btn_1 appears on btn_level 2 (sync) + DEBOUNCE_CYCLES + 1 clocks later.
//  - Pulse timing: press_pulse/release_pulse assert in the same cycle btn_level changes.
//    - They are never both high at once.
//    - They are never high for 2 consecutive cycles, except repeat pulses spaced REPEAT_PERIOD apart.
//  - btn_level changes only on the IDLE<->PRESSED transitions. It is held 1 through RELEASE_WAIT
//    and held 0 through PRESS_WAIT.
//  - Reset mid-operation: returns to IDLE with no pulse. A button still held after reset must pass
//    a full debounce, then gives a single press_pulse.
//  - Glitches shorter than 2 clocks may be absorbed by the synchroniser; either outcome is legal.
// CONFIGURATION
//  Macro BTN_DEBOUNCE_PULSE_AUTOREPEAT_EN
//  - Defined: a repeat counter runs in PRESSED.
//    - First extra press_pulse after REPEAT_DELAY clocks in PRESSED.
//    - Further pulses every REPEAT_PERIOD clocks.
//    - Repeat counter clears on leaving PRESSED. RELEASE_WAIT pauses repeating, and bouncing back
//      to PRESSED restarts REPEAT_DELAY.
//  - Undefined: exactly one press_pulse per accepted press. REPEAT_* parameters are ignored and
//    no repeat logic is synthesised.
// STRUCTURE
//  - Package btn_pkg:
//    - state enum {IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT} in a 2-bit encoding.
//    - Board constants CLK_HZ=100_000_000 and DEBOUNCE_MS=20.
//  - Sub-module sync_2ff (1-bit, reset to 0 with rst_n), reused by later input stages.
//  - All FSM, counter and pulse logic stays inside btn_debounce_pulse.
// TESTING
//  - Sim params: DEBOUNCE_CYCLES=8, REPEAT_DELAY=40, REPEAT_PERIOD=16.
//  1. Reset held 3 clks with btn_1=1 -> all outputs 0.
//     After release: press_pulse once at clk 2+8+1=11, then btn_level=1.
//  2. btn_1 toggles 0/1 every 3 clks for 30 clks, then stays 1
//     -> no pulse during the bouncing; one press_pulse 11 clks after it settles.
//  3. Clean press, hold 20 clks, clean release -> press_pulse x1, btn_level 1 for about 20 clks,
//     release_pulse x1, never coincident.
//  4. While PRESSED, 4-clk low glitch -> btn_level stays 1; no release_pulse.
//  5. rst_n=0 for 1 clk while in RELEASE_WAIT -> outputs 0 next clk; no release_pulse.
//  6. With AUTOREPEAT_EN, hold 100 clks -> press_pulse at t0, t0+40, t0+56, t0+72, t0+88.
//     Without the macro: only t0.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared board constants and debounce FSM state type for the EGO1 push-button input stages.
package btn_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'b00,
    PRESS_WAIT   = 2'b01,
    PRESSED      = 2'b10,
    RELEASE_WAIT = 2'b11
  } btn_state_t;

  localparam int unsigned CLK_HZ      = 100_000_000;
  localparam int unsigned DEBOUNCE_MS = 20;

  // Default debounce window in clocks (20 ms at the 100 MHz board clock).
  localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = (CLK_HZ / 1000) * DEBOUNCE_MS;

endpackage

// File: rtl/btn_debounce_pulse_sync_2ff.sv
// sync_2ff: single-bit two-flop synchroniser with synchronous active-low reset to 0.
// Shared by the board's input conditioning stages.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  // Two back-to-back flops resolve metastability on the asynchronous input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/btn_debounce_pulse.sv
// btn_debounce_pulse: synchronises and debounces the S1 push-button, producing a clean
// registered level plus one-clock press/release strobes.
// Optional auto-repeat of press_pulse while held: define BTN_DEBOUNCE_PULSE_AUTOREPEAT_EN.
module btn_debounce_pulse
  import btn_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int unsigned REPEAT_DELAY    = 50_000_000,
  parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_1,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);

  localparam int unsigned     CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);

  // Reject degenerate configurations at elaboration time.
  if (DEBOUNCE_CYCLES < 1 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
    $error("btn_debounce_pulse: DEBOUNCE_CYCLES, REPEAT_DELAY and REPEAT_PERIOD must be >= 1");
  end

  logic             s;
  btn_state_t       state;
  logic [CNT_W-1:0] cnt;

`ifdef BTN_DEBOUNCE_PULSE_AUTOREPEAT_EN
  localparam int unsigned      RPT_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY
                                                                           : REPEAT_PERIOD;
  localparam int unsigned      RPT_W      = $clog2(RPT_MAX + 1);
  localparam logic [RPT_W-1:0] RPT_DELAY  = RPT_W'(REPEAT_DELAY - 1);
  localparam logic [RPT_W-1:0] RPT_PERIOD = RPT_W'(REPEAT_PERIOD - 1);

  logic [RPT_W-1:0] rpt_cnt;
  // Set once the first (delayed) repeat has fired; later repeats use the shorter period.
  logic             rpt_armed;
`endif

  sync_2ff u_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (btn_1),
    .q     (s)
  );

  // Debounce FSM: counter, level and strobes all registered together.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
`ifdef BTN_DEBOUNCE_PULSE_AUTOREPEAT_EN
      rpt_cnt       <= '0;
      rpt_armed     <= 1'b0;
`endif
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (s) begin
            state <= PRESS_WAIT;
            cnt   <= '0;
          end
        end

        PRESS_WAIT: begin
          if (!s) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (cnt == CNT_LAST) begin
            state       <= PRESSED;
            cnt         <= '0;
            btn_level   <= 1'b1;
            press_pulse <= 1'b1;
`ifdef BTN_DEBOUNCE_PULSE_AUTOREPEAT_EN
            rpt_cnt     <= '0;
            rpt_armed   <= 1'b0;
`endif
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        PRESSED: begin
          if (!s) begin
            state <= RELEASE_WAIT;
            cnt   <= '0;
`ifdef BTN_DEBOUNCE_PULSE_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
`endif
          end else begin
`ifdef BTN_DEBOUNCE_PULSE_AUTOREPEAT_EN
            if (rpt_armed ? (rpt_cnt == RPT_PERIOD) : (rpt_cnt == RPT_DELAY)) begin
              press_pulse <= 1'b1;
              rpt_cnt     <= '0;
              rpt_armed   <= 1'b1;
            end else begin
              rpt_cnt <= rpt_cnt + RPT_W'(1);
            end
`endif
          end
        end

        RELEASE_WAIT: begin
          if (s) begin
            // Bounce back to pressed: repeat timing restarts from the full delay.
            state <= PRESSED;
            cnt   <= '0;
`ifdef BTN_DEBOUNCE_PULSE_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_armed <= 1'b0;
`endif
          end else if (cnt == CNT_LAST) begin
            state         <= IDLE;
            cnt           <= '0;
            btn_level     <= 1'b0;
            release_pulse <= 1'b1;
          end else if (cnt != CNT_MAX) begin
            cnt <= cnt + CNT_W'(1);
          end
        end

        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

endmodule
